// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: register file geometry defaults and named register indices.
package mips_pkg;
   localparam int DEF_DATA_W   = 32;
   localparam int DEF_ADDR_W   = 5;
   localparam int DEF_NUM_REGS = 32;

   localparam logic [4:0] REG_ZERO = 5'd0;
   localparam logic [4:0] REG_SP   = 5'd29;
   localparam logic [4:0] REG_RA   = 5'd31;

   function automatic logic is_zero_reg(input logic [4:0] idx);
      return idx == REG_ZERO;
   endfunction
endpackage

// File: rtl/register_file_read_port.sv
// One combinational read port: array mux, $zero force, and write-through bypass
// when REGFILE_BYPASS_EN is defined.
module regfile_read_port
   import mips_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_REGS = DEF_NUM_REGS
) (
   input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
   input  logic [ADDR_W-1:0]               addr,
   input  logic                            reset_n,
   input  logic                            should_write,
   input  logic [ADDR_W-1:0]               write_addr,
   input  logic [DATA_W-1:0]               write_data,
   output logic [DATA_W-1:0]               data
);
   logic addr_zero;
   assign addr_zero = (addr == ADDR_W'(REG_ZERO));

`ifdef REGFILE_BYPASS_EN
   logic bypass_hit;
   assign bypass_hit = reset_n && should_write && (write_addr != ADDR_W'(REG_ZERO))
                       && (write_addr == addr);
`else
   logic unused_bypass;
   assign unused_bypass = ^{reset_n, should_write, write_addr, write_data};
`endif

   always_comb begin
      data = regs[addr];
      if (addr_zero) data = '0;
`ifdef REGFILE_BYPASS_EN
      // In-flight WB result wins over the stored value so ID sees it a cycle early.
      if (bypass_hit) data = write_data;
`endif
   end
endmodule

// File: rtl/register_file.sv
// 32x32 MIPS GPR file: two combinational read ports, one synchronous write port, $zero hardwired.
// Optional write-through bypass enabled by defining REGFILE_BYPASS_EN.
module register_file
   import mips_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_REGS = DEF_NUM_REGS
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] read_addr_1,
   input  logic [ADDR_W-1:0] read_addr_2,
   output logic [DATA_W-1:0] read_data_1,
   output logic [DATA_W-1:0] read_data_2,
   input  logic              should_write,
   input  logic [ADDR_W-1:0] write_addr,
   input  logic [DATA_W-1:0] write_data
);
   localparam int NUM_RD = 2;

   logic [NUM_REGS-1:0][DATA_W-1:0] regs;
   logic [NUM_RD-1:0][ADDR_W-1:0]   rd_addr;
   logic [NUM_RD-1:0][DATA_W-1:0]   rd_data;

   // Entry 0 is never written, so it stays at its reset value of 0.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         regs <= '0;
      else if (should_write && (write_addr != ADDR_W'(REG_ZERO)))
         regs[write_addr] <= write_data;
   end

   assign rd_addr     = {read_addr_2, read_addr_1};
   assign read_data_1 = rd_data[0];
   assign read_data_2 = rd_data[1];

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      regfile_read_port #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .NUM_REGS (NUM_REGS)
      ) u_rd (
         .regs         (regs),
         .addr         (rd_addr[p]),
         .reset_n      (reset_n),
         .should_write (should_write),
         .write_addr   (write_addr),
         .write_data   (write_data),
         .data         (rd_data[p])
      );
   end
endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic
// against an array model, checked every cycle just before the rising edge.
`timescale 1ns/10ps
module tb_register_file;
   logic        clock;
   logic        reset_n;
   logic [4:0]  read_addr_1, read_addr_2, write_addr;
   logic [31:0] read_data_1, read_data_2, write_data;
   logic        should_write;

   int n_checks = 0;
   int n_fail   = 0;
   bit model_on = 0;

`ifdef REGFILE_BYPASS_EN
   localparam bit BYP = 1;
`else
   localparam bit BYP = 0;
`endif

   register_file dut (
      .clock(clock), .reset_n(reset_n),
      .read_addr_1(read_addr_1), .read_addr_2(read_addr_2),
      .read_data_1(read_data_1), .read_data_2(read_data_2),
      .should_write(should_write), .write_addr(write_addr), .write_data(write_data)
   );

   initial clock = 0;
   always #1 clock = ~clock;

   // Architectural state as the programmer sees it.
   logic [31:0] mdl [32];

   always @(negedge reset_n) for (int i = 0; i < 32; i++) mdl[i] <= 32'd0;

   always @(posedge clock)
      if (reset_n && should_write && write_addr != 5'd0) mdl[write_addr] <= write_data;

   function automatic logic [31:0] exp_rd(input logic [4:0] a);
      if (!reset_n) return 32'd0;
      if (BYP && should_write && write_addr != 5'd0 && a == write_addr) return write_data;
      if (a == 5'd0) return 32'd0;
      return mdl[a];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      #0.5;
      if (model_on) begin
         check("model_rd1", read_data_1, exp_rd(read_addr_1));
         check("model_rd2", read_data_2, exp_rd(read_addr_2));
      end
   end

   task automatic tick;
      @(posedge clock);
      #0.2;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 0; should_write = 0; write_addr = 0; write_data = 0;
      read_addr_1 = 0; read_addr_2 = 0;
      #0.5 reset_n = 1;
      tick;
      model_on = 1;

      // 1. reset wipes state immediately, no edge needed
      should_write = 1; write_addr = 5; write_data = 32'hDEADBEEF; read_addr_1 = 5;
      tick;
      should_write = 0;
      #0.1 check("r5_before_reset", read_data_1, 32'hDEADBEEF);
      #0.2 reset_n = 0;
      #0.1 check("r5_async_reset", read_data_1, 32'd0);
      for (int i = 0; i < 32; i++) begin
         @(posedge clock); #0.5;
         read_addr_1 = 5'(i); read_addr_2 = 5'(31 - i);
         #0.4;
         check("reset_sweep_p1", read_data_1, 32'd0);
         check("reset_sweep_p2", read_data_2, 32'd0);
      end
      #0.1 reset_n = 1;
      tick;

      // 2. write, then a non-write must not disturb it
      should_write = 1; write_addr = 8; write_data = 100; read_addr_1 = 8;
      tick;
      should_write = 0; write_data = 5;
      #1.2 check("r8_after_write", read_data_1, 32'd100);
      tick;
      #1.2 check("r8_after_nowrite", read_data_1, 32'd100);
      tick;

      // 3. $zero ignores writes
      should_write = 1; write_addr = 0; write_data = 44; read_addr_1 = 0; read_addr_2 = 0;
      #1.2 check("r0_p1_pre", read_data_1, 32'd0);
      check("r0_p2_pre", read_data_2, 32'd0);
      tick;
      should_write = 0;
      #1.2 check("r0_p1_post", read_data_1, 32'd0);
      check("r0_p2_post", read_data_2, 32'd0);
      tick;

      // 4. same-cycle read of the write target
      should_write = 1; write_addr = 31; write_data = 32'h12345678; read_addr_2 = 31;
      read_addr_1 = 31;
      #1.2 check("r31_pre_edge", read_data_2, BYP ? 32'h12345678 : 32'd0);
      check("r31_ports_agree", read_data_1, read_data_2);
      tick;
      should_write = 0;
      #1.2 check("r31_post_edge", read_data_2, 32'h12345678);
      tick;

      // 5. dual-port sweep
      for (int i = 1; i < 32; i++) begin
         should_write = 1; write_addr = 5'(i); write_data = 32'(i * 3);
         tick;
      end
      should_write = 0;
      for (int i = 0; i < 32; i++) begin
         read_addr_1 = 5'(i); read_addr_2 = 5'(31 - i);
         #1.2;
         check("sweep_p1", read_data_1, 32'(i * 3));
         check("sweep_p2", read_data_2, 32'((31 - i) * 3));
         tick;
      end

      // 6. writes during reset are ignored, bypass included
      reset_n = 0; should_write = 1; write_addr = 9; write_data = 7; read_addr_1 = 9;
      #0.1 check("r9_in_reset", read_data_1, 32'd0);
      tick;
      tick;
      reset_n = 1; should_write = 0;
      #1.2 check("r9_after_reset", read_data_1, 32'd0);
      check("r6_cleared", mdl[6], 32'd0);
      tick;

      // randomized traffic, with occasional short reset pulses inside a cycle
      for (int c = 0; c < 400; c++) begin
         should_write = ($urandom_range(0, 3) != 0);
         write_addr   = 5'($urandom_range(0, 31));
         write_data   = $urandom;
         read_addr_1  = ($urandom_range(0, 2) == 0) ? write_addr : 5'($urandom_range(0, 31));
         read_addr_2  = ($urandom_range(0, 2) == 0) ? write_addr : 5'($urandom_range(0, 31));
         if ($urandom_range(0, 60) == 0) begin
            #0.3 reset_n = 0;
            #0.2 reset_n = 1;
         end
         tick;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
